// File: rtl/periph_intc_pkg.sv
// periph_intc_pkg: shared data-word type and register-offset encoding for the interrupt controller.
package periph_intc_pkg;

    typedef logic [31:0] word;

    typedef enum logic [2:0] {
        REG_STATUS      = 3'd0,
        REG_RAW         = 3'd1,
        REG_ENABLE      = 3'd2,
        REG_ENABLE_SET  = 3'd3,
        REG_ENABLE_CLR  = 3'd4,
        REG_PENDING_CLR = 3'd5,
        REG_CLAIM       = 3'd6,
        REG_EDGE        = 3'd7
    } intc_reg;

endpackage

// File: rtl/periph_intc_prio.sv
// periph_intc_prio: combinational lowest-index priority encoder used for the CLAIM readout.
module periph_intc_prio #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [4:0]   id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Scan downwards so the lowest requesting index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 5'(i);
            end
        end
    end

endmodule

// File: rtl/periph_intc.sv
// periph_intc: synchronised edge/level interrupt collector with MMIO enable, pending-clear and claim
// registers, driving a registered level irq to the core.
module periph_intc
    import periph_intc_pkg::*;
#(
    parameter int NUM_SOURCES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SOURCES-1:0] src,
    input  logic [2:0]             addr,
    input  logic                   read,
    input  logic                   write,
    input  word                    writedata,
    output word                    readdata,
    output logic                   ready,
    output logic                   irq
);

    localparam int N = NUM_SOURCES;

    logic [N-1:0] s1_q, s2_q, prev_q, pending_q, enable_q, edge_q;
    logic [N-1:0] pending_d, enable_d, edge_d;
    logic [N-1:0] wdata, hit, win, clr;
    logic         irq_q, irq_d, ready_q, ready_d;
    logic         claim_valid, unused_wdata;
    logic [4:0]   claim_id;
    word          readdata_q, readdata_d, reg_val;
    intc_reg      reg_sel;
    logic         wr_enable, wr_set, wr_clr, wr_pclr, wr_edge, rd_claim;

    assign reg_sel      = intc_reg'(addr);
    assign wdata        = writedata[N-1:0];
    assign unused_wdata = ^writedata;
    assign hit          = pending_q & enable_q;
    // Two's-complement trick isolates the lowest set bit: the claim winner as a one-hot mask.
    assign win          = hit & (~hit + N'(1));

    periph_intc_prio #(.N(N)) u_prio (
        .req   (hit),
        .valid (claim_valid),
        .id    (claim_id)
    );

    always_comb begin
        case (reg_sel)
            REG_STATUS: reg_val = word'(hit);
            REG_RAW:    reg_val = word'(pending_q);
            REG_ENABLE: reg_val = word'(enable_q);
            REG_CLAIM:  reg_val = {claim_valid, 26'b0, claim_id};
            REG_EDGE:   reg_val = word'(edge_q);
            default:    reg_val = '0;
        endcase
        wr_enable  = write && reg_sel == REG_ENABLE;
        wr_set     = write && reg_sel == REG_ENABLE_SET;
        wr_clr     = write && reg_sel == REG_ENABLE_CLR;
        wr_pclr    = write && reg_sel == REG_PENDING_CLR;
        wr_edge    = write && reg_sel == REG_EDGE;
        rd_claim   = read && reg_sel == REG_CLAIM;
        enable_d   = wr_enable ? wdata :
                     wr_set    ? (enable_q | wdata) :
                     wr_clr    ? (enable_q & ~wdata) : enable_q;
        edge_d     = wr_edge ? wdata : edge_q;
        clr        = (wr_pclr ? wdata : '0) | (rd_claim ? win : '0);
        // A fresh rising edge is OR-ed in after the clear so it wins over a same-cycle clear.
        pending_d  = (edge_q & ((pending_q & ~clr) | (s2_q & ~prev_q))) | (~edge_q & s2_q);
        pending_d  = wr_edge ? (pending_d & ~(wdata & ~edge_q)) : pending_d;
        irq_d      = |hit;
        ready_d    = read | write;
        readdata_d = read ? reg_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            edge_q     <= '0;
            irq_q      <= 1'b0;
            ready_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            s1_q       <= src;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            irq_q      <= irq_d;
            ready_q    <= ready_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq      = irq_q;
    assign ready    = ready_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_periph_intc.sv
// tb_periph_intc: directed and randomised bus/src traffic checked every cycle against a
// history-based behavioural model, plus literal expectations for the key scenarios.
module tb_periph_intc;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  src = '0;
    logic [2:0]    addr = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          ready, irq;
    int            checks = 0;
    int            errors = 0;

    periph_intc #(.NUM_SOURCES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src),
        .addr      (addr),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .ready     (ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Model: h1/h2/h3 are the src samples taken 1, 2 and 3 clock edges ago.
    logic [N-1:0] m_pend, m_en, m_edge, h1, h2, h3;
    logic         m_irq, m_ready;
    logic [31:0]  m_rdata;

    function automatic logic [31:0] claim_val(input logic [N-1:0] p, input logic [N-1:0] e);
        for (int i = 0; i < N; i++)
            if (p[i] && e[i]) return 32'h8000_0000 | 32'(i);
        return 32'h0;
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_pend & m_en);
            3'd1: return 32'(m_pend);
            3'd2: return 32'(m_en);
            3'd6: return claim_val(m_pend, m_en);
            3'd7: return 32'(m_edge);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [N-1:0] next_pend();
        logic [N-1:0] p = m_pend;
        logic [31:0]  c = claim_val(m_pend, m_en);
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (write && addr == 3'd5 && writedata[i]) p[i] = 1'b0;
                if (read && addr == 3'd6 && c[31] && c[4:0] == i[4:0]) p[i] = 1'b0;
                if (h2[i] && !h3[i]) p[i] = 1'b1;
            end else begin
                p[i] = h2[i];
            end
            if (write && addr == 3'd7 && writedata[i] && !m_edge[i]) p[i] = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [N-1:0] next_en();
        if (!write) return m_en;
        case (addr)
            3'd2: return writedata[N-1:0];
            3'd3: return m_en | writedata[N-1:0];
            3'd4: return m_en & ~writedata[N-1:0];
            default: return m_en;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= '0;
            m_en    <= '0;
            m_edge  <= '0;
            m_irq   <= 1'b0;
            m_ready <= 1'b0;
            m_rdata <= '0;
            h1      <= '0;
            h2      <= '0;
            h3      <= '0;
        end else begin
            m_pend  <= next_pend();
            m_en    <= next_en();
            m_edge  <= (write && addr == 3'd7) ? writedata[N-1:0] : m_edge;
            m_irq   <= |(m_pend & m_en);
            m_ready <= read | write;
            m_rdata <= read ? reg_val(addr) : 32'h0;
            h1      <= src;
            h2      <= h1;
            h3      <= h2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("irq", 32'(irq), 32'(m_irq));
        chk("ready", 32'(ready), 32'(m_ready));
        if (ready) chk("readdata", readdata, m_rdata);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        read = 1'b1; addr = a;
        @(negedge clk);
        d = readdata;
        read = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        src = '1;
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        rst_n = 1'b1;
        rd(3'd2, d);
        chk("enable_after_rst", d, 32'h0);
        src = '0;
        cyc(4);

        wr(3'd7, 32'h8);
        wr(3'd3, 32'h8);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        cyc(2);
        chk("edge_irq_e2", 32'(irq), 32'h0);
        cyc(1);
        chk("edge_irq_e3", 32'(irq), 32'h1);
        rd(3'd6, d);
        chk("claim_edge3", d, 32'h8000_0003);
        cyc(1);
        chk("irq_after_claim", 32'(irq), 32'h0);

        src[5] = 1'b1; src[2] = 1'b1;
        wr(3'd3, 32'h24);
        cyc(4);
        rd(3'd6, d);
        chk("claim_level2", d, 32'h8000_0002);
        wr(3'd5, 32'h20);
        cyc(1);
        rd(3'd1, d);
        chk("raw_level_kept", d, 32'h24);
        chk("irq_level", 32'(irq), 32'h1);
        src[2] = 1'b0;
        cyc(5);
        chk("irq_one_level", 32'(irq), 32'h1);
        src[5] = 1'b0;
        cyc(5);
        chk("irq_levels_gone", 32'(irq), 32'h0);

        wr(3'd7, 32'h88);
        src[7] = 1'b1;
        cyc(2);
        wr(3'd5, 32'h80);
        rd(3'd1, d);
        chk("edge_beats_clr", d & 32'h80, 32'h80);
        wr(3'd5, 32'h80);
        rd(3'd1, d);
        chk("edge_clr_held", d & 32'h80, 32'h0);

        src[5] = 1'b1;
        cyc(4);
        chk("irq_src5", 32'(irq), 32'h1);
        wr(3'd4, 32'h20);
        cyc(1);
        chk("irq_disabled", 32'(irq), 32'h0);
        rd(3'd1, d);
        chk("raw_retained", d & 32'h20, 32'h20);
        wr(3'd3, 32'h20);
        cyc(1);
        chk("irq_reenabled", 32'(irq), 32'h1);

        read = 1'b1; write = 1'b1; addr = 3'd2; writedata = 32'hF;
        @(negedge clk);
        d = readdata;
        read = 1'b0; write = 1'b0;
        chk("rw_old_value", d, 32'h2C);
        chk("rw_ready", 32'(ready), 32'h1);
        cyc(1);
        chk("ready_one_cycle", 32'(ready), 32'h0);
        rd(3'd2, d);
        chk("rw_new_value", d, 32'hF);

        #2 rst_n = 1'b0;
        cyc(2);
        chk("midrst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        cyc(4);
        rd(3'd1, d);
        chk("level_after_rst", d, 32'hA0);
        chk("irq_after_rst", 32'(irq), 32'h0);

        for (int k = 0; k < 3000; k++) begin
            src       = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            read      = ($urandom_range(0, 2) == 0);
            write     = ($urandom_range(0, 3) == 0);
            addr      = 3'($urandom_range(0, 7));
            writedata = $urandom;
            if (k == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        read = 1'b0; write = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
